// File: rtl/rram_pkg.sv
// rram_pkg: shared state encoding, geometry and default latencies
// for the RRAM bit-cell array responder.
package rram_pkg;
    typedef enum logic [2:0] {UNFORMED, FORM, IDLE, WRITE, READ} state_t;
    localparam int ADDR_W       = 5;
    localparam int DEPTH        = 32;
    localparam int WR_LAT_DEF   = 2;
    localparam int RD_LAT_DEF   = 1;
    localparam int FORM_LAT_DEF = 4;
endpackage

// File: rtl/rram_cell_array.sv
// rram_cell_array: 32x1 bit cells with a synchronous write/clear port,
// a combinational read port and an asynchronous clear on reset.
module rram_cell_array
    import rram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);
    logic [DEPTH-1:0] cells_q, cells_d;

    always_comb begin
        cells_d = cells_q;
        if (clr) cells_d = '0;
        else if (we) cells_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cells_q <= '0;
        else        cells_q <= cells_d;
    end

    assign rdata = cells_q[raddr];
endmodule

// File: rtl/rram_array_responder.sv
// rram_array_responder: serial single-bit RRAM responder with forming,
// fixed-latency write and read operations over a shared tri-state data pin.
module rram_array_responder
    import rram_pkg::*;
#(
    parameter int WR_LAT   = WR_LAT_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int FORM_LAT = FORM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rram_ce,
    input  logic              rram_we,
    input  logic              rram_re,
    input  logic              rram_forming,
    input  logic [ADDR_W-1:0] rram_add,
    inout  wire               rram_data,
    output logic              rram_busy,
    output logic              rram_formed
);
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wdat_q, wdat_d;
    logic              formed_q, formed_d;
    logic              avail, last, cell_we, cell_clr, drive, cell_bit;

    assign avail = !rram_ce && !rram_busy;
    assign last  = cnt_q == 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= UNFORMED;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdat_q   <= 1'b0;
            formed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            formed_q <= formed_d;
        end
    end

    // Busy states share one countdown; the edge that sees cnt==1 finishes the op.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        formed_d = formed_q;
        case (state_q)
            UNFORMED: begin
                if (avail && rram_forming) begin
                    state_d = FORM;
                    cnt_d   = 3'(FORM_LAT);
                end
            end
            IDLE: begin
                if (avail && rram_we) begin
                    state_d = WRITE;
                    cnt_d   = 3'(WR_LAT);
                    addr_d  = rram_add;
                    wdat_d  = rram_data;
                end else if (avail && rram_re) begin
                    state_d = READ;
                    cnt_d   = 3'(RD_LAT);
                    addr_d  = rram_add;
                end
            end
            default: begin
                cnt_d = cnt_q - 3'd1;
                if (last) begin
                    state_d  = IDLE;
                    formed_d = formed_q || state_q == FORM;
                end
            end
        endcase
    end

    always_comb begin
        rram_busy = state_q inside {FORM, WRITE, READ};
        cell_clr  = state_q == FORM && last;
        cell_we   = state_q == WRITE && last;
        drive     = state_q == READ && last;
    end

    assign rram_formed = formed_q;
    assign rram_data   = drive ? cell_bit : 1'bz;

    rram_cell_array u_cells (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cell_clr),
        .we    (cell_we),
        .waddr (addr_q),
        .wdata (wdat_q),
        .raddr (addr_q),
        .rdata (cell_bit)
    );
endmodule

// File: tb/tb_rram_array_responder.sv
// tb_rram_array_responder: directed table plus randomized transactions checked
// against a transaction-level memory model; the data pin is pulled up so an
// undriven (high-Z) pin reads as 1.
module tb_rram_array_responder;
    localparam int WL = 2;
    localparam int RL = 1;
    localparam int FL = 4;

    typedef struct {
        int kind;
        int addr;
        bit dat;
        bit exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rram_ce = 1'b1;
    logic       rram_we = 1'b0;
    logic       rram_re = 1'b0;
    logic       rram_forming = 1'b0;
    logic [4:0] rram_add = '0;
    logic       tb_oe = 1'b0;
    logic       tb_dat = 1'b0;
    wire        rram_data_w;
    logic       rram_busy, rram_formed;

    int          n_tests = 0;
    int          n_fail = 0;
    bit          mem[32];
    logic [31:0] pat, word;
    logic        last_rd;
    vec_t        tbl[$];

    assign rram_data_w = tb_oe ? tb_dat : 1'bz;
    pullup (rram_data_w);

    rram_array_responder #(.WR_LAT(WL), .RD_LAT(RL), .FORM_LAT(FL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rram_ce      (rram_ce),
        .rram_we      (rram_we),
        .rram_re      (rram_re),
        .rram_forming (rram_forming),
        .rram_add     (rram_add),
        .rram_data    (rram_data_w),
        .rram_busy    (rram_busy),
        .rram_formed  (rram_formed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic quiet();
        rram_ce = 1'b1;
        rram_we = 1'b0;
        rram_re = 1'b0;
        rram_forming = 1'b0;
        tb_oe = 1'b0;
    endtask

    // Called at a negedge with the block idle; leaves at the negedge of the first free cycle.
    // kind: 0 write, 1 read, 2 write+read together, 3 forming.
    task automatic op(input int kind, input int a, input bit d, input bit e);
        int lat;
        chk("busy_before_op", rram_busy, 1'b0);
        rram_ce = 1'b0;
        rram_we = kind == 0 || kind == 2;
        rram_re = kind == 1 || kind == 2;
        rram_forming = kind == 3;
        rram_add = 5'(a);
        tb_oe = kind == 0 || kind == 2;
        tb_dat = d;
        lat = kind == 3 ? FL : (kind == 1 ? RL : WL);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("busy_during_op", rram_busy, 1'b1);
            if (kind == 1 && k == lat) begin
                last_rd = rram_data_w;
                chk("read_bit", rram_data_w, e);
            end else if (kind == 1) chk("hiz_before_drive", rram_data_w, 1'b1);
            rram_ce = 1'($urandom);
            rram_we = 1'($urandom);
            rram_re = 1'($urandom);
            rram_forming = 1'($urandom);
            rram_add = 5'($urandom);
            tb_oe = 1'b0;
        end
        @(negedge clk);
        quiet();
        chk("busy_after_op", rram_busy, 1'b0);
        chk("hiz_after_op", rram_data_w, 1'b1);
        if (kind == 3) begin
            chk("formed_after_form", rram_formed, 1'b1);
            foreach (mem[j]) mem[j] = 1'b0;
        end
        if (kind == 0 || kind == 2) mem[a] = d;
    endtask

    task automatic idle_chk();
        rram_ce = 1'b1;
        rram_we = 1'($urandom);
        rram_re = 1'($urandom);
        rram_forming = 1'($urandom);
        @(negedge clk);
        quiet();
        chk("idle_ce_high_busy", rram_busy, 1'b0);
    endtask

    initial begin
        pat = 32'h00005A93;
        for (int i = 0; i < 32; i++) tbl.push_back('{0, i, pat[i], 1'b0});
        for (int i = 0; i < 32; i++) tbl.push_back('{1, i, 1'b0, pat[i]});
        tbl.push_back('{2, 7, 1'b1, 1'b0});
        tbl.push_back('{1, 7, 1'b0, 1'b1});
        tbl.push_back('{0, 7, 1'b0, 1'b0});
        tbl.push_back('{1, 7, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        chk("reset_busy", rram_busy, 1'b0);
        chk("reset_formed", rram_formed, 1'b0);
        chk("reset_hiz", rram_data_w, 1'b1);
        rst_n = 1'b1;

        // Requests before forming are ignored.
        rram_ce = 1'b0; rram_we = 1'b1; rram_add = 5'd3; tb_oe = 1'b1; tb_dat = 1'b1;
        @(negedge clk);
        chk("unformed_we_busy", rram_busy, 1'b0);
        tb_oe = 1'b0; rram_we = 1'b0; rram_re = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("unformed_re_busy", rram_busy, 1'b0);
            chk("unformed_re_hiz", rram_data_w, 1'b1);
        end
        quiet();
        chk("unformed_formed", rram_formed, 1'b0);

        op(3, 0, 1'b0, 1'b0);
        rram_ce = 1'b0; rram_forming = 1'b1;
        @(negedge clk);
        chk("idle_forming_busy", rram_busy, 1'b0);
        quiet();
        @(negedge clk);
        chk("idle_forming_busy2", rram_busy, 1'b0);
        chk("idle_forming_formed", rram_formed, 1'b1);
        op(1, 3, 1'b0, 1'b0);

        word = '0;
        foreach (tbl[i]) begin
            op(tbl[i].kind, tbl[i].addr, tbl[i].dat, tbl[i].exp);
            if (i >= 32 && i < 64) word[tbl[i].addr] = last_rd;
        end
        n_tests++;
        if (word !== 32'h00005A93) begin
            n_fail++;
            $display("FAIL pattern_word: got %h required %h", word, 32'h00005A93);
        end

        for (int n = 0; n < 80; n++) begin
            int kind, a;
            bit d;
            kind = $urandom_range(0, 2);
            a = $urandom_range(0, 31);
            d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle_chk();
            op(kind, a, d, mem[a]);
        end

        // Reset in the second write cycle aborts the write.
        rram_ce = 1'b0; rram_we = 1'b1; rram_add = 5'd9; tb_oe = 1'b1; tb_dat = 1'b1;
        @(negedge clk);
        chk("abort_wr_busy1", rram_busy, 1'b1);
        quiet();
        @(negedge clk);
        chk("abort_wr_busy2", rram_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_drop", rram_busy, 1'b0);
        chk("abort_formed_drop", rram_formed, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_hiz", rram_data_w, 1'b1);
        op(3, 0, 1'b0, 1'b0);
        op(1, 9, 1'b0, 1'b0);
        chk("reform_read9", last_rd, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rram_array_responder.md
RRAM_ARRAY_RESPONDER -- requirements
Module: rram_array_responder

Interface
REQ-001 SHALL have parameter WR_LAT, default 2, cycles a SET/RESET write pulse occupies (1..7).
REQ-002 SHALL have parameter RD_LAT, default 1, cycles from read acceptance to the bit appearing on rram_data (1..7).
REQ-003 SHALL have parameter FORM_LAT, default 4, cycles of the forming operation (1..7).
REQ-004 SHALL have port clk  input  1  single clock, all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rram_ce  input  1  chip select, active-low.
REQ-007 SHALL have port rram_we  input  1  write request.
REQ-008 SHALL have port rram_re  input  1  read request.
REQ-009 SHALL have port rram_forming  input  1  forming request.
REQ-010 SHALL have port rram_add  input  5  bit-cell address, 0..31.
REQ-011 SHALL have port rram_data  inout  1  serial bit: sampled on write, driven on read, high-Z otherwise.
REQ-012 SHALL have port rram_busy  output  1  operation in progress; requests ignored while high.
REQ-013 SHALL have port rram_formed  output  1  array has been formed.

Function
REQ-014 SHALL implement a state machine with states UNFORMED, FORM, IDLE, WRITE and READ.
REQ-015 SHALL accept a request only on an edge where rram_ce=0, rram_busy=0 and the request input is 1. Priority: forming, then we, then re.
REQ-016 In UNFORMED, SHALL accept only forming (-> FORM) and SHALL ignore we/re; rram_data stays high-Z.
REQ-017 SHALL hold rram_busy=1 for exactly FORM_LAT cycles in FORM. On leaving FORM it SHALL set all 32 cells to 0, set rram_formed=1 and go to IDLE.
REQ-018 In IDLE, forming SHALL be a no-op: no busy, no state change, cells unchanged.
REQ-019 On write acceptance, SHALL capture rram_add and rram_data on that same edge.
REQ-020 After write acceptance, SHALL hold rram_busy=1 for exactly WR_LAT cycles, update the addressed cell on the last of those edges, then return to IDLE.
REQ-021 On read acceptance, SHALL capture rram_add.
REQ-022 After read acceptance, SHALL drive rram_data with the addressed cell for exactly one cycle, the RD_LAT-th cycle after acceptance. rram_busy SHALL be 1 from the cycle after acceptance through that drive cycle, then the block returns to IDLE.
REQ-023 When we and re are requested together, SHALL perform the write only.
REQ-024 SHALL complete an accepted operation even if rram_ce or a request input deasserts mid-operation.
REQ-025 SHALL take the first cycle after busy falls as accept-eligible, giving back-to-back operations with no dead cycle.
REQ-026 SHALL keep the latency counter 3 bits wide, counting down from the latency parameter to 1.
REQ-027 SHALL drive rram_data high-Z in every cycle other than a read drive cycle.

Reset
REQ-028 While rst_n=0, SHALL immediately force: state UNFORMED, rram_busy=0, rram_formed=0, rram_data high-Z, counter 0, all cells 0.
REQ-029 Reset mid-operation SHALL abort the operation with no partial cell update.

Structure
REQ-030 Package rram_pkg SHALL hold the state enum, ADDR_W=5, DEPTH=32 and the default latency constants.
REQ-031 Storage SHALL be one sub-module, rram_cell_array: 32x1 cells, synchronous write port, combinational read port, async clear.

Verification
REQ-032 Bench SHALL cover: rram_we=1 with rram_add=3, rram_data=1 before forming -> no busy; a later read of 3 after forming returns 0.
REQ-033 Bench SHALL cover: forming pulse -> busy for 4 cycles, then rram_formed=1.
REQ-034 Bench SHALL cover: serial write of pattern 0x5A93 over addresses 0..31, each issued on the first cycle busy is low -> each write holds busy for exactly 2 cycles.
REQ-035 Bench SHALL cover: reading addresses 0..31 back -> each bit on rram_data exactly 1 cycle after acceptance, the 32 bits equal 0x00005A93, and rram_data is high-Z in all other cycles.
REQ-036 Bench SHALL cover: we=re=1 at address 7 with data 1 -> write only; a following read of 7 returns 1.
REQ-037 Bench SHALL cover: rst_n=0 during the second WRITE cycle at address 9 -> busy drops immediately, rram_formed=0, and after re-forming a read of 9 returns 0.
